// File: rtl/bin_bbox_tracker.sv
// Per-colour bounding box and set-pixel counter over a raster-scanned binary frame.
// Optional macro BIN_BBOX_CENTROID_SUM_EN adds per-colour x/y coordinate sums.
module bin_bbox_tracker #(
    parameter int CW = 12,
    parameter int NW = 24
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_red_threshold,
    input  logic            in_green_threshold,
    input  logic            in_blue_threshold,
    input  logic            in_valid_threshold,
    input  logic            in_frame_start,
    input  logic [CW-1:0]   in_width,
    input  logic [CW-1:0]   in_height,
    output logic [4*CW-1:0] out_red_box,
    output logic [4*CW-1:0] out_green_box,
    output logic [4*CW-1:0] out_blue_box,
    output logic [NW-1:0]   out_red_count,
    output logic [NW-1:0]   out_green_count,
    output logic [NW-1:0]   out_blue_count,
    output logic            out_done,
    output logic            out_frame_error
`ifdef BIN_BBOX_CENTROID_SUM_EN
    ,
    output logic [CW+NW-1:0] out_red_sum_x,
    output logic [CW+NW-1:0] out_red_sum_y,
    output logic [CW+NW-1:0] out_green_sum_x,
    output logic [CW+NW-1:0] out_green_sum_y,
    output logic [CW+NW-1:0] out_blue_sum_x,
    output logic [CW+NW-1:0] out_blue_sum_y
`endif
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [CW-1:0]   C_ONES   = '1;
    localparam logic [CW-1:0]   C_ONE    = CW'(1);
    localparam logic [NW-1:0]   N_ONES   = '1;
    localparam logic [NW-1:0]   N_ONE    = NW'(1);
    localparam logic [4*CW-1:0] BOX_NONE = {C_ONES, {CW{1'b0}}, C_ONES, {CW{1'b0}}};

    function automatic logic [NW-1:0] sat_inc(input logic [NW-1:0] v);
        return (v == N_ONES) ? v : v + N_ONE;
    endfunction

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_width, r_height, r_x, r_y;
    logic [CW-1:0]   w_width_e, w_height_e, w_x_e, w_y_e, w_x_nxt, w_y_nxt;
    logic [2:0]      w_bits;
    logic            w_dims_ok, w_active_e, w_pix, w_last, w_err_nxt;

    logic [NW-1:0]   r_cnt  [3];
    logic [CW-1:0]   r_xmin [3];
    logic [CW-1:0]   r_xmax [3];
    logic [CW-1:0]   r_ymin [3];
    logic [CW-1:0]   r_ymax [3];
    logic [NW-1:0]   w_cnt  [3];
    logic [CW-1:0]   w_xmin [3];
    logic [CW-1:0]   w_xmax [3];
    logic [CW-1:0]   w_ymin [3];
    logic [CW-1:0]   w_ymax [3];

    logic [4*CW-1:0] r_out_box [3];
    logic [NW-1:0]   r_out_cnt [3];
    logic            r_done, r_err;

`ifdef BIN_BBOX_CENTROID_SUM_EN
    logic [CW+NW-1:0] r_sx [3];
    logic [CW+NW-1:0] r_sy [3];
    logic [CW+NW-1:0] w_sx [3];
    logic [CW+NW-1:0] w_sy [3];
    logic [CW+NW-1:0] r_out_sx [3];
    logic [CW+NW-1:0] r_out_sy [3];
`endif

    // A frame start in this cycle restarts first, so the pixel logic sees the fresh frame.
    always_comb begin
        w_bits     = {in_blue_threshold, in_green_threshold, in_red_threshold};
        w_dims_ok  = (in_width != '0) && (in_height != '0);
        w_width_e  = in_frame_start ? in_width  : r_width;
        w_height_e = in_frame_start ? in_height : r_height;
        w_x_e      = in_frame_start ? '0 : r_x;
        w_y_e      = in_frame_start ? '0 : r_y;
        w_active_e = in_frame_start ? w_dims_ok : (r_state == ACTIVE);
        w_pix      = w_active_e && in_valid_threshold;
        w_last     = w_pix && (w_x_e == w_width_e - C_ONE) && (w_y_e == w_height_e - C_ONE);
        w_err_nxt  = in_frame_start &&
                     (!w_dims_ok || ((r_state == ACTIVE) && ((r_x != '0) || (r_y != '0))));

        w_state_nxt = r_state;
        if (in_frame_start) begin
            w_state_nxt = w_dims_ok ? ACTIVE : IDLE;
        end
        if (w_last) begin
            w_state_nxt = IDLE;
        end

        w_x_nxt = w_x_e;
        w_y_nxt = w_y_e;
        if (w_last) begin
            w_x_nxt = '0;
            w_y_nxt = '0;
        end else if (w_pix) begin
            if (w_x_e == w_width_e - C_ONE) begin
                w_x_nxt = '0;
                w_y_nxt = w_y_e + C_ONE;
            end else begin
                w_x_nxt = w_x_e + C_ONE;
            end
        end

        for (int c = 0; c < 3; c++) begin
            w_cnt[c]  = in_frame_start ? '0     : r_cnt[c];
            w_xmin[c] = in_frame_start ? C_ONES : r_xmin[c];
            w_xmax[c] = in_frame_start ? '0     : r_xmax[c];
            w_ymin[c] = in_frame_start ? C_ONES : r_ymin[c];
            w_ymax[c] = in_frame_start ? '0     : r_ymax[c];
`ifdef BIN_BBOX_CENTROID_SUM_EN
            w_sx[c]   = in_frame_start ? '0 : r_sx[c];
            w_sy[c]   = in_frame_start ? '0 : r_sy[c];
`endif
            if (w_pix && w_bits[c]) begin
                w_cnt[c] = sat_inc(w_cnt[c]);
                if (w_x_e < w_xmin[c]) w_xmin[c] = w_x_e;
                if (w_x_e > w_xmax[c]) w_xmax[c] = w_x_e;
                if (w_y_e < w_ymin[c]) w_ymin[c] = w_y_e;
                if (w_y_e > w_ymax[c]) w_ymax[c] = w_y_e;
`ifdef BIN_BBOX_CENTROID_SUM_EN
                w_sx[c] = w_sx[c] + {{NW{1'b0}}, w_x_e};
                w_sy[c] = w_sy[c] + {{NW{1'b0}}, w_y_e};
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_width  <= '0;
            r_height <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                r_cnt[c]     <= '0;
                r_xmin[c]    <= C_ONES;
                r_xmax[c]    <= '0;
                r_ymin[c]    <= C_ONES;
                r_ymax[c]    <= '0;
                r_out_box[c] <= BOX_NONE;
                r_out_cnt[c] <= '0;
`ifdef BIN_BBOX_CENTROID_SUM_EN
                r_sx[c]      <= '0;
                r_sy[c]      <= '0;
                r_out_sx[c]  <= '0;
                r_out_sy[c]  <= '0;
`endif
            end
        end else begin
            r_width  <= w_width_e;
            r_height <= w_height_e;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_done   <= w_last;
            r_err    <= w_err_nxt;
            for (int c = 0; c < 3; c++) begin
                if (w_last) begin
                    // Publish the finished frame, then start the accumulators from empty.
                    r_out_box[c] <= {w_xmin[c], w_xmax[c], w_ymin[c], w_ymax[c]};
                    r_out_cnt[c] <= w_cnt[c];
                    r_cnt[c]     <= '0;
                    r_xmin[c]    <= C_ONES;
                    r_xmax[c]    <= '0;
                    r_ymin[c]    <= C_ONES;
                    r_ymax[c]    <= '0;
`ifdef BIN_BBOX_CENTROID_SUM_EN
                    r_out_sx[c]  <= w_sx[c];
                    r_out_sy[c]  <= w_sy[c];
                    r_sx[c]      <= '0;
                    r_sy[c]      <= '0;
`endif
                end else begin
                    r_cnt[c]     <= w_cnt[c];
                    r_xmin[c]    <= w_xmin[c];
                    r_xmax[c]    <= w_xmax[c];
                    r_ymin[c]    <= w_ymin[c];
                    r_ymax[c]    <= w_ymax[c];
`ifdef BIN_BBOX_CENTROID_SUM_EN
                    r_sx[c]      <= w_sx[c];
                    r_sy[c]      <= w_sy[c];
`endif
                end
            end
        end
    end

    assign out_red_box     = r_out_box[0];
    assign out_green_box   = r_out_box[1];
    assign out_blue_box    = r_out_box[2];
    assign out_red_count   = r_out_cnt[0];
    assign out_green_count = r_out_cnt[1];
    assign out_blue_count  = r_out_cnt[2];
    assign out_done        = r_done;
    assign out_frame_error = r_err;

`ifdef BIN_BBOX_CENTROID_SUM_EN
    assign out_red_sum_x   = r_out_sx[0];
    assign out_red_sum_y   = r_out_sy[0];
    assign out_green_sum_x = r_out_sx[1];
    assign out_green_sum_y = r_out_sy[1];
    assign out_blue_sum_x  = r_out_sx[2];
    assign out_blue_sum_y  = r_out_sy[2];
`endif

endmodule

// File: doc/bin_bbox_tracker.md
BIN_BBOX_TRACKER -- requirements
Module: bin_bbox_tracker

Interface
REQ-001 SHALL have parameter CW, default 12: coordinate width in bits.
REQ-002 SHALL have parameter NW, default 24: pixel-count width in bits.
REQ-003 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports in_red_threshold, in_green_threshold, in_blue_threshold, each input, 1: per-colour binary pixel.
REQ-006 SHALL have port in_valid_threshold, input, 1: qualifies the binary pixel bits.
REQ-007 SHALL have port in_frame_start, input, 1: one-cycle pulse marking the start of a new frame.
REQ-008 SHALL have ports in_width and in_height, each input, CW: frame dimensions, sampled on in_frame_start.
REQ-009 SHALL have ports out_red_box, out_green_box, out_blue_box, each output, 4*CW: bounding box packed {xmin,xmax,ymin,ymax}.
REQ-010 SHALL have ports out_red_count, out_green_count, out_blue_count, each output, NW: set-pixel count.
REQ-011 SHALL have port out_done, output, 1: one-cycle pulse when results update.
REQ-012 SHALL have port out_frame_error, output, 1: one-cycle pulse on an aborted or illegal frame.

Function
REQ-013 SHALL implement states IDLE and ACTIVE; after reset the state SHALL be IDLE, and pixels in IDLE SHALL be ignored.
REQ-014 in_frame_start SHALL latch in_width/in_height, clear x, y and all accumulators, and enter ACTIVE, in any state.
REQ-015 A latched in_width or in_height of 0 SHALL pulse out_frame_error the next cycle and return to IDLE.
REQ-016 In ACTIVE, each in_valid_threshold cycle SHALL be pixel (x,y); x SHALL increment, wrap to 0 at width-1, and increment y on wrap.
REQ-017 For each colour bit set on a valid pixel: count +1, saturating at 2^NW-1; xmin/xmax/ymin/ymax SHALL update by unsigned min/max.
REQ-018 On the valid pixel at (width-1,height-1), on the next edge: outputs SHALL load the final accumulators including that pixel, out_done SHALL pulse, accumulators SHALL clear, and the state SHALL return to IDLE.
REQ-019 A colour with count 0 SHALL report box {all ones, 0, all ones, 0}.
REQ-020 in_frame_start while ACTIVE with (x,y) != (0,0) SHALL pulse out_frame_error; outputs SHALL hold previous values.
REQ-021 in_frame_start coincident with in_valid_threshold SHALL restart first, then count that pixel as (0,0) of the new frame.
REQ-022 Outputs SHALL change only on out_done and hold otherwise; latency from the last pixel to out_done SHALL be 1 cycle.

Reset
REQ-023 Reset SHALL force IDLE, x=y=0, all counts 0, all boxes {all ones,0,all ones,0}, out_done=0 and out_frame_error=0.
REQ-024 Reset SHALL take priority over in_frame_start and pixel input in the same cycle; a frame in progress SHALL be discarded without an error pulse.

Configuration
REQ-025 Macro BIN_BBOX_CENTROID_SUM_EN, when defined, SHALL add outputs out_<colour>_sum_x and out_<colour>_sum_y (CW+NW bits each): sums of x and y over set pixels, updated and cleared with the counts, reset to 0.
REQ-026 Without BIN_BBOX_CENTROID_SUM_EN, these ports and their accumulators SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-027 width=4, height=3, red set only at (1,1) and (2,2) -> out_done 1 cycle after the 12th pixel; red box {1,2,1,2}, red count 2; green and blue count 0 with box {FFF,0,FFF,0}.
REQ-028 width=4, height=3, all bits set every pixel, valid gapped every other cycle -> each colour box {0,3,0,2}, count 12, exactly one out_done.
REQ-029 in_frame_start after 5 pixels of a 4x3 frame -> out_frame_error pulse, outputs unchanged, new frame completes normally.
REQ-030 in_frame_start with width=0 -> out_frame_error next cycle, no out_done on subsequent pixels.
REQ-031 Reset asserted mid-frame, then a new frame -> no error pulse; results reflect the new frame only.
REQ-032 With BIN_BBOX_CENTROID_SUM_EN, 4x3 frame, blue set at (3,0) and (1,2) -> blue sum_x 4, sum_y 2, count 2.
